// File: rtl/dsm_sample_sched_pkg.sv
// Shared types and helpers for the delta-sigma sample scheduler.
package dsm_sample_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STARVED = 2'd2
  } state_t;

  // Ceiling log2 usable in constant expressions (port widths, localparams).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Offset-binary zero: 2^(width-1).
  function automatic logic [31:0] midscale(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/dsm_pair_fifo.sv
// Synchronous FIFO of stereo pairs with an extra pointer bit to tell full
// from empty. Flush clears it in one cycle and overrides push and pop.
module dsm_pair_fifo
  import dsm_sample_sched_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   aclr_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic [clog2(DEPTH):0]  o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (o_level == (AW + 1)'(DEPTH));
  assign o_empty   = (o_level == '0);
  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign w_push_ok = i_push && !o_full && !i_flush;
  assign w_pop_ok  = i_pop && !o_empty && !i_flush;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush empties the FIFO by rewinding both pointers.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
    end
  end

  // Storage write.
  // NOTE: the array has no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/dsm_sample_sched.sv
// Sample-rate scheduler: buffers stereo PCM pairs and presents one pair per
// sample tick to the delta-sigma modulator, handling prime/underrun/disable.
module dsm_sample_sched
  import dsm_sample_sched_pkg::*;
#(
  parameter int DSM_WIDTH   = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRIME_LEVEL = 2,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        aclr_n,
  input  logic                        enable,
  input  logic [DIV_WIDTH-1:0]        rate_div,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DSM_WIDTH-1:0]        in_left,
  input  logic [DSM_WIDTH-1:0]        in_right,
  output logic [DSM_WIDTH-1:0]        left_pcm,
  output logic [DSM_WIDTH-1:0]        right_pcm,
  output logic                        sample_tick,
  output logic [clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                        running,
  output logic                        underrun,
  input  logic                        underrun_clr
);

  localparam int LVL_W = clog2(FIFO_DEPTH) + 1;
  localparam logic [DSM_WIDTH-1:0] MIDSCALE  = DSM_WIDTH'(midscale(DSM_WIDTH));
  localparam logic [LVL_W-1:0]     PRIME_LVL = LVL_W'(PRIME_LEVEL);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [DIV_WIDTH-1:0]    r_cnt;
  logic                    w_tick;
  logic                    w_pop;
  logic                    w_starve;
  logic                    w_force_mid;
  logic                    w_full;
  logic                    w_empty;
  logic [2*DSM_WIDTH-1:0]  w_fifo_data;

  dsm_pair_fifo #(
    .WIDTH (2 * DSM_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .aclr_n  (aclr_n),
    .i_flush (!enable),
    .i_push  (in_valid),
    .i_pop   (w_pop),
    .i_data  ({in_left, in_right}),
    .o_data  (w_fifo_data),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign in_ready = !w_full;
  // Counter parked at 0 while disabled, so the first enabled cycle ticks.
  assign w_tick   = enable && (r_cnt == '0);

  // Rate divider: count down, reload rate_div on reaching zero.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n)             r_cnt <= '0;
    else if (!enable)        r_cnt <= '0;
    else if (r_cnt == '0)    r_cnt <= rate_div;
    else                     r_cnt <= r_cnt - DIV_WIDTH'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // FSM next-state logic; disable overrides every state.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    w_next_state = r_state;
    if (!enable) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (fifo_level >= PRIME_LVL) w_next_state = ST_RUN;
        ST_RUN:     if (w_starve)                w_next_state = ST_STARVED;
        ST_STARVED: if (w_pop)                   w_next_state = ST_RUN;
        default:                                 w_next_state = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: pop/starve decisions use the registered FIFO level, so a
  // same-cycle push into an empty FIFO is not seen by this tick.
  always_comb begin
    running     = (r_state != ST_IDLE);
    w_pop       = w_tick && running && !w_empty;
    w_starve    = w_tick && (r_state == ST_RUN) && w_empty;
    w_force_mid = !enable || (r_state == ST_IDLE);
  end

  // Modulator-facing registers: load a popped pair, park at midscale when
  // idle or disabled, otherwise hold the last sample.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      left_pcm    <= MIDSCALE;
      right_pcm   <= MIDSCALE;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= w_pop;
      if (w_pop) begin
        left_pcm  <= w_fifo_data[2*DSM_WIDTH-1:DSM_WIDTH];
        right_pcm <= w_fifo_data[DSM_WIDTH-1:0];
      end else if (w_force_mid) begin
        left_pcm  <= MIDSCALE;
        right_pcm <= MIDSCALE;
      end
    end
  end

  // Sticky underrun flag; a new underrun beats a simultaneous clear.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n)           underrun <= 1'b0;
    else if (w_starve)     underrun <= 1'b1;
    else if (underrun_clr) underrun <= 1'b0;
  end

endmodule

// File: tb/tb_dsm_sample_sched.sv
// Self-checking bench for dsm_sample_sched: directed scenarios with literal
// expectations plus a randomized phase, all cross-checked every cycle
// against a queue-based behavioural model.
module tb_dsm_sample_sched;

  localparam int          DEPTH = 4;
  localparam int          PRIME = 2;
  localparam logic [11:0] MID   = 12'h800;

  logic        clk = 1'b0;
  logic        aclr_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] rate_div = 16'd3;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_left = '0;
  logic [11:0] in_right = '0;
  logic [11:0] left_pcm;
  logic [11:0] right_pcm;
  logic        sample_tick;
  logic [2:0]  fifo_level;
  logic        running;
  logic        underrun;
  logic        underrun_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  always #5 clk = ~clk;

  dsm_sample_sched dut (
    .clk          (clk),
    .aclr_n       (aclr_n),
    .enable       (enable),
    .rate_div     (rate_div),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_left      (in_left),
    .in_right     (in_right),
    .left_pcm     (left_pcm),
    .right_pcm    (right_pcm),
    .sample_tick  (sample_tick),
    .fifo_level   (fifo_level),
    .running      (running),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode: 0 idle, 1 run, 2 starved. Ticks are tracked as absolute edge
  // numbers: the next tick edge, rescheduled rate_div+1 edges later.
  logic [23:0] q[$];
  int          m_mode  = 0;
  logic [11:0] e_l     = MID;
  logic [11:0] e_r     = MID;
  bit          e_tick  = 0;
  bit          e_und   = 0;
  int          cyc     = 0;
  int          tick_at = 0;

  task automatic model_reset();
    q.delete();
    m_mode  = 0;
    e_l     = MID;
    e_r     = MID;
    e_tick  = 0;
    e_und   = 0;
    tick_at = cyc;
  endtask

  task automatic model_step();
    int lvl;
    bit tick;
    bit pop;
    bit starve;
    lvl = q.size();
    if (!enable) begin
      q.delete();
      m_mode  = 0;
      e_l     = MID;
      e_r     = MID;
      e_tick  = 0;
      if (underrun_clr) e_und = 0;
      tick_at = cyc + 1;
    end else begin
      tick = (cyc == tick_at);
      if (tick) tick_at = cyc + int'(rate_div) + 1;
      pop    = tick && (m_mode != 0) && (lvl > 0);
      starve = tick && (m_mode == 1) && (lvl == 0);
      e_tick = pop;
      if (pop) begin
        e_l = q[0][23:12];
        e_r = q[0][11:0];
      end else if (m_mode == 0) begin
        e_l = MID;
        e_r = MID;
      end
      case (m_mode)
        0: if (lvl >= PRIME) m_mode = 1;
        1: if (starve)       m_mode = 2;
        default: if (pop)    m_mode = 1;
      endcase
      if (pop) void'(q.pop_front());
      if (in_valid && lvl < DEPTH) q.push_back({in_left, in_right});
      if (starve) e_und = 1;
      else if (underrun_clr) e_und = 0;
    end
    cyc++;
  endtask

  // Advance the model on every edge (or async reset) and compare 1 ns later.
  always @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) model_reset();
    else         model_step();
    #1;
    if (chk_en) begin
      check("m_left",     left_pcm,    e_l);
      check("m_right",    right_pcm,   e_r);
      check("m_tick",     sample_tick, e_tick);
      check("m_level",    fifo_level,  q.size());
      check("m_running",  running,     m_mode != 0);
      check("m_underrun", underrun,    e_und);
      check("m_in_ready", in_ready,    q.size() != DEPTH);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < max);
    check("wait_sample_tick", sample_tick, 1);
  endtask

  task automatic wait_underrun(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!underrun && n < max);
    check("wait_underrun", underrun, 1);
  endtask

  task automatic push_pair(input logic [11:0] l, input logic [11:0] r);
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    #2 chk_en = 1;
    repeat (3) @(negedge clk);
    aclr_n = 1'b1;
    @(negedge clk);

    // Reset then idle.
    check("rst_left",     left_pcm,    12'h800);
    check("rst_right",    right_pcm,   12'h800);
    check("rst_in_ready", in_ready,    1);
    check("rst_underrun", underrun,    0);
    check("rst_level",    fifo_level,  0);
    check("rst_running",  running,     0);

    // Prime and run: enable with the two pushes (pushes while disabled
    // would be flushed).
    rate_div = 16'd3;
    enable   = 1'b1;
    push_pair(12'h100, 12'h200);
    push_pair(12'h300, 12'h400);
    check("prime_level",   fifo_level, 2);
    check("prime_idle",    running,    0);
    @(negedge clk);
    check("prime_running", running,    1);
    wait_tick(20, n);
    check("run_left0",  left_pcm,  12'h100);
    check("run_right0", right_pcm, 12'h200);
    wait_tick(20, n);
    check("run_spacing", 32'(n), 4);
    check("run_left1",  left_pcm,  12'h300);
    check("run_right1", right_pcm, 12'h400);

    // Underrun: next tick finds the FIFO empty.
    wait_underrun(20, n);
    check("und_spacing", 32'(n), 4);
    check("und_running", running,     1);
    check("und_no_tick", sample_tick, 0);
    check("und_left",    left_pcm,    12'h300);
    check("und_right",   right_pcm,   12'h400);
    push_pair(12'hABC, 12'h123);
    wait_tick(20, n);
    check("starve_wait", 32'(n), 3);
    check("starve_left",  left_pcm,  12'hABC);
    check("starve_right", right_pcm, 12'h123);
    check("starve_running",  running,  1);
    check("starve_und_held", underrun, 1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("und_cleared", underrun, 0);

    // Full FIFO with a very slow tick.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rate_div = 16'hFFFF;
    enable   = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_left  = 12'h010 + 12'(i);
      in_right = 12'h020 + 12'(i);
      @(negedge clk);
    end
    check("full_ready", in_ready,   0);
    check("full_level", fifo_level, 4);
    in_left  = 12'h055;
    in_right = 12'h066;
    repeat (3) @(negedge clk);
    check("full_hold_ready", in_ready,   0);
    check("full_hold_level", fifo_level, 4);
    in_valid = 1'b0;

    // Disable mid-stream with three entries left.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rate_div = 16'd7;
    enable   = 1'b1;
    for (int i = 0; i < 4; i++) push_pair(12'hA01 + 12'(i), 12'hB01 + 12'(i));
    wait_tick(20, n);
    check("dis_pre_left",  left_pcm,   12'hA01);
    check("dis_pre_level", fifo_level, 3);
    check("dis_pre_run",   running,    1);
    enable = 1'b0;
    @(negedge clk);
    check("dis_level",   fifo_level, 0);
    check("dis_left",    left_pcm,   12'h800);
    check("dis_right",   right_pcm,  12'h800);
    check("dis_running", running,    0);
    check("dis_ready",   in_ready,   1);

    // Async reset mid-operation, with underrun set and non-midscale outputs.
    rate_div = 16'd1;
    enable   = 1'b1;
    push_pair(12'h5A5, 12'h3C3);
    push_pair(12'h6B6, 12'h4D4);
    wait_underrun(40, n);
    check("ar_pre_left", left_pcm, 12'h6B6);
    @(posedge clk);
    #2 aclr_n = 1'b0;
    #1;
    check("ar_left",     left_pcm,    12'h800);
    check("ar_right",    right_pcm,   12'h800);
    check("ar_underrun", underrun,    0);
    check("ar_running",  running,     0);
    check("ar_level",    fifo_level,  0);
    check("ar_ready",    in_ready,    1);
    check("ar_tick",     sample_tick, 0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    aclr_n = 1'b1;
    @(negedge clk);

    // Randomized traffic against the model.
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      in_valid     = ($urandom_range(0, 99) < 55);
      in_left      = 12'($urandom);
      in_right     = 12'($urandom);
      underrun_clr = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 2) rate_div = 16'($urandom_range(0, 5));
      if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 99) < 30) enable = 1'b1;
      @(negedge clk);
    end
    in_valid     = 1'b0;
    underrun_clr = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
